// File: rtl/rpu_pkg.sv
// rpu_pkg -- shared helpers for the NE_rpu saturating datapath blocks.
//   sat_max(w)       : largest value of a w-bit signed two's-complement number
//   sat_min(w)       : smallest value of a w-bit signed two's-complement number
//   sat_resize(x, w) : clamp an integer into the w-bit signed range
package rpu_pkg;

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   function automatic longint sat_resize(input longint x, input int w);
      if (x > sat_max(w)) begin
         return sat_max(w);
      end else if (x < sat_min(w)) begin
         return sat_min(w);
      end
      return x;
   endfunction

endpackage

// File: rtl/sat_adder_tree_if.sv
// sat_adder_tree_if -- streaming bundle of the N-operand saturating adder.
//   in_data/in_valid/in_ready/in_acc/in_start : input beat and its sidebands
//   out_data/out_valid/out_ready/out_sat      : saturated result beat
//   ovf_sticky/ovf_clr                        : sticky overflow flag and its clear
// slave is the adder side, master is the source/sink side.
interface sat_adder_tree_if #(
   parameter int W = 6,
   parameter int N = 4
);
   logic [N*W-1:0]        in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_acc;
   logic                  in_start;
   logic signed [W-1:0]   out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_sat;
   logic                  ovf_sticky;
   logic                  ovf_clr;

   modport slave (
      input  in_data, in_valid, in_acc, in_start, out_ready, ovf_clr,
      output in_ready, out_data, out_valid, out_sat, ovf_sticky
   );

   modport master (
      output in_data, in_valid, in_acc, in_start, out_ready, ovf_clr,
      input  in_ready, out_data, out_valid, out_sat, ovf_sticky
   );
endinterface

// File: rtl/sat_clip.sv
// sat_clip -- combinational clip of a WI-bit signed value to W bits.
//   x   : WI-bit signed input (WI > W)
//   y   : W-bit signed result, pinned at the W-bit limits when x is out of range
//   sat : 1 when y differs from x (the value was clipped)
module sat_clip
   import rpu_pkg::*;
#(
   parameter int WI = 8,
   parameter int W  = 6
) (
   input  logic signed [WI-1:0] x,
   output logic signed [W-1:0]  y,
   output logic                 sat
);
   localparam logic signed [WI-1:0] HI = WI'(sat_max(W));
   localparam logic signed [WI-1:0] LO = WI'(sat_min(W));

   always_comb begin
      y   = x[W-1:0];
      sat = 1'b0;
      if (x > HI) begin
         y   = HI[W-1:0];
         sat = 1'b1;
      end else if (x < LO) begin
         y   = LO[W-1:0];
         sat = 1'b1;
      end
   end
endmodule

// File: rtl/sat_adder_tree.sv
// sat_adder_tree -- pipelined N-operand saturating adder with optional accumulate.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : sat_adder_tree_if.slave (input beat, result beat, sticky overflow)
// Operands are summed at full precision (W+LVL bits) through LVL registered
// tree levels; a final stage adds the accumulator base and saturates once to W.
// Latency is LVL+1 cycles; a stalled output freezes the whole pipeline.
module sat_adder_tree
   import rpu_pkg::*;
#(
   parameter int W = 6,
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             rst,
   sat_adder_tree_if.slave  bus
);
   localparam int LVL = $clog2(N);
   localparam int WS  = W + LVL;
   localparam int N2  = 1 << LVL;   // operand count padded to a power of two
   localparam int NN  = N2 - 1;     // registered tree nodes (heap order, root = 0)

   logic                 en;
   logic signed [WS-1:0] tree_all [2*N2-1];  // nodes followed by leaves
   logic signed [WS-1:0] node_p   [NN];
   logic [LVL-1:0]       vld_p;
   logic [LVL-1:0]       acc_p;
   logic [LVL-1:0]       start_p;

   logic signed [W-1:0]  acc_reg;
   logic signed [W-1:0]  out_data_p;
   logic                 out_valid_p;
   logic                 out_sat_p;
   logic                 ovf_sticky_p;

   logic signed [WS:0]   root_x;
   logic signed [WS:0]   base_x;
   logic signed [WS:0]   sum_x;
   logic signed [W-1:0]  clip_y;
   logic                 clip_sat;

   // Any held output freezes every stage; bubbles stay in place.
   assign en           = !(out_valid_p && !bus.out_ready);
   assign bus.in_ready = en;

   // Leaves: sign-extended operands, zero padding beyond N.
   for (genvar i = 0; i < 2*N2-1; i++) begin : g_tree
      if (i < NN) begin : g_node
         assign tree_all[i] = node_p[i];
      end else if (i - NN < N) begin : g_leaf
         assign tree_all[i] = {{LVL{bus.in_data[(i-NN)*W + W-1]}}, bus.in_data[(i-NN)*W +: W]};
      end else begin : g_pad
         assign tree_all[i] = '0;
      end
   end

   // Tree stages p0..p(LVL-1): each node registers the sum of its two children,
   // so depth d of the heap lands in stage LVL-1-d.
   always_ff @(posedge clk) begin
      if (en) begin
         acc_p[0]   <= bus.in_acc;
         start_p[0] <= bus.in_start;
         for (int s = 1; s < LVL; s++) begin
            acc_p[s]   <= acc_p[s-1];
            start_p[s] <= start_p[s-1];
         end
         for (int i = 0; i < NN; i++) begin
            node_p[i] <= tree_all[2*i+1] + tree_all[2*i+2];
         end
      end
   end

   // Saturate/accumulate stage.
   always_comb begin
      root_x = {node_p[0][WS-1], node_p[0]};
      base_x = '0;
      if (acc_p[LVL-1] && !start_p[LVL-1]) begin
         base_x = {{(WS+1-W){acc_reg[W-1]}}, acc_reg};
      end
      sum_x = root_x + base_x;
   end

   sat_clip #(
      .WI (WS + 1),
      .W  (W)
   ) u_clip (
      .x   (sum_x),
      .y   (clip_y),
      .sat (clip_sat)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p        <= '0;
         out_valid_p  <= 1'b0;
         out_data_p   <= '0;
         out_sat_p    <= 1'b0;
         acc_reg      <= '0;
         ovf_sticky_p <= 1'b0;
      end else begin
         if (en) begin
            vld_p[0] <= bus.in_valid;
            for (int s = 1; s < LVL; s++) begin
               vld_p[s] <= vld_p[s-1];
            end
            out_valid_p <= vld_p[LVL-1];
            if (vld_p[LVL-1]) begin
               out_data_p <= clip_y;
               out_sat_p  <= clip_sat;
               if (acc_p[LVL-1]) begin
                  acc_reg <= clip_y;
               end
            end
         end
         // A clipped beat leaving in the same cycle as a clear keeps the flag set.
         if (out_valid_p && bus.out_ready && out_sat_p) begin
            ovf_sticky_p <= 1'b1;
         end else if (bus.ovf_clr) begin
            ovf_sticky_p <= 1'b0;
         end
      end
   end

   assign bus.out_data   = out_data_p;
   assign bus.out_valid  = out_valid_p;
   assign bus.out_sat    = out_sat_p;
   assign bus.ovf_sticky = ovf_sticky_p;
endmodule

// File: tb/tb_sat_adder_tree.sv
// tb_sat_adder_tree -- directed vectors for sat_adder_tree (W=6, N=4) with a
// queue scoreboard: the driver pushes the hand-computed result of each accepted
// beat, and a monitor pops and compares on every output handshake.
module tb_sat_adder_tree;
   localparam int W = 6;
   localparam int N = 4;

   typedef struct packed {
      logic signed [W-1:0] d;
      logic                s;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   sat_adder_tree_if #(.W(W), .N(N)) bus ();

   sat_adder_tree #(.W(W), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one pop per handshake (out_valid && out_ready seen before the edge).
   always @(negedge clk) begin
      exp_t e;
      if (rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d, expected no beat (t=%0t)",
                     $signed(bus.out_data), $time);
         end else begin
            e = sb.pop_front();
            check("out_data", int'($signed(bus.out_data)), int'($signed(e.d)));
            check("out_sat", int'(bus.out_sat), int'(e.s));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic send(input int a, input int b, input int c, input int d,
                       input logic acc, input logic start,
                       input int ed, input logic es, input bit push);
      int   n;
      exp_t e;
      bus.in_data  = {W'(d), W'(c), W'(b), W'(a)};
      bus.in_acc   = acc;
      bus.in_start = start;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept", int'(bus.in_ready), 1);
      if (push && bus.in_ready) begin
         e.d = W'(ed);
         e.s = es;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(bus.out_valid), 1);
   endtask

   initial begin
      int lat;
      rst          = 1'b0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.in_acc   = 1'b0;
      bus.in_start = 1'b0;
      bus.out_ready = 1'b1;
      bus.ovf_clr  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", int'($signed(bus.out_data)), 0);
      check("rst_out_sat", int'(bus.out_sat), 0);
      check("rst_ovf_sticky", int'(bus.ovf_sticky), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      rst = 1'b1;
      @(negedge clk);

      // Plain sum and latency.
      send(3, 4, -2, 10, 1'b0, 1'b0, 15, 1'b0, 1'b1);
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 3);
      drain();

      // Clipping both ways and full-precision cancellation.
      send(31, 31, 31, 31, 1'b0, 1'b0, 31, 1'b1, 1'b1);
      send(-32, -32, -32, -32, 1'b0, 1'b0, -32, 1'b1, 1'b1);
      send(31, 31, -32, -30, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      drain();
      check("ovf_sticky_set", int'(bus.ovf_sticky), 1);
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      check("ovf_sticky_clr", int'(bus.ovf_sticky), 0);

      // Accumulate with saturation, start-without-acc ignored, pass-through leaves acc alone.
      send(10, 0, 0, 0, 1'b1, 1'b1, 10, 1'b0, 1'b1);
      send(10, 0, 0, 0, 1'b1, 1'b0, 20, 1'b0, 1'b1);
      send(15, 0, 0, 0, 1'b1, 1'b0, 31, 1'b1, 1'b1);
      send(-10, 0, 0, 0, 1'b1, 1'b0, 21, 1'b0, 1'b1);
      send(5, 0, 0, 0, 1'b0, 1'b1, 5, 1'b0, 1'b1);
      send(1, 0, 0, 0, 1'b1, 1'b0, 22, 1'b0, 1'b1);
      drain();
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;

      // Backpressure: 4-cycle output stall in the middle of a 6-beat stream.
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               send(i, 0, 0, 0, 1'b0, 1'b0, i, 1'b0, 1'b1);
            end
         end
         begin
            logic signed [W-1:0] hold;
            wait_out_valid("stall_setup");
            @(posedge clk);
            #2 bus.out_ready = 1'b0;
            #1;
            hold = bus.out_data;
            check("in_ready_comb_low", int'(bus.in_ready), 0);
            repeat (4) begin
               @(negedge clk);
               check("stall_valid", int'(bus.out_valid), 1);
               check("stall_hold", int'($signed(bus.out_data)), int'(hold));
               check("stall_in_ready", int'(bus.in_ready), 0);
            end
            @(posedge clk);
            #2 bus.out_ready = 1'b1;
            #1;
            check("in_ready_comb_high", int'(bus.in_ready), 1);
         end
      join
      @(negedge clk);
      drain();

      // Reset mid-stream: sticky set and accumulator loaded, then two beats discarded.
      send(31, 31, 31, 31, 1'b0, 1'b0, 31, 1'b1, 1'b1);
      send(10, 0, 0, 0, 1'b1, 1'b1, 10, 1'b0, 1'b1);
      drain();
      check("pre_rst_sticky", int'(bus.ovf_sticky), 1);
      send(7, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      send(8, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_ovf_sticky", int'(bus.ovf_sticky), 0);
      rst = 1'b1;
      @(negedge clk);
      send(5, 0, 0, 0, 1'b1, 1'b0, 5, 1'b0, 1'b1);
      drain();

      // Clear in the same cycle as a clipping handshake: set wins.
      send(31, 31, 31, 31, 1'b0, 1'b0, 31, 1'b1, 1'b1);
      wait_out_valid("clip_out_valid");
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      check("clr_vs_set", int'(bus.ovf_sticky), 1);
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      check("clr_after", int'(bus.ovf_sticky), 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule
